// File: rtl/affhl_pkg.sv
// Shared definitions for the float-to-fixed converter family: controller
// state encoding, shift-amount width helper and saturation constants.
package affhl_pkg;

    // Widest fixed-point result the saturation helpers can describe.
    localparam int MAX_FIXEDSIZE = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CALC  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_NEG   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Width of the signed shift amount: wide enough for radix + exponent
    // sums plus a sign bit and one bit of headroom.
    function automatic int shift_width(input int exp_bits, input int radix_bits);
        return ((exp_bits > radix_bits) ? exp_bits : radix_bits) + 2;
    endfunction

    // Largest positive two's-complement value of the given width.
    function automatic logic [MAX_FIXEDSIZE-1:0] sat_maxpos(input int width);
        return (MAX_FIXEDSIZE'(1) << (width - 1)) - MAX_FIXEDSIZE'(1);
    endfunction

    // Most negative two's-complement value of the given width.
    function automatic logic [MAX_FIXEDSIZE-1:0] sat_maxneg(input int width);
        return MAX_FIXEDSIZE'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/float_shift_plan.sv
// Combinational shift planner: decodes a float and radix point into the
// significand, shift direction, shift count and early overflow flags.
module float_shift_plan
    import affhl_pkg::*;
#(
    parameter int FLOATSIZE      = 32,
    parameter int FIXEDSIZE      = 32,
    parameter int RADIXPOINTSIZE = 6,
    parameter int EXPONENTBITS   = 8,
    parameter int MANTISSABITS   = 23,
    parameter int BIAS           = 127,
    parameter int CNTW           = 6
) (
    input  logic [FLOATSIZE-1:0]      i_float,
    input  logic [RADIXPOINTSIZE-1:0] i_radix,
    output logic [FIXEDSIZE-1:0]      o_sig,
    output logic                      o_sign,
    output logic [CNTW-1:0]           o_count,
    output logic                      o_left,
    output logic                      o_pre_overflow,
    output logic                      o_special
);

    localparam int SW = shift_width(EXPONENTBITS, RADIXPOINTSIZE);
    localparam logic signed [SW-1:0] C_MANT = SW'(MANTISSABITS);
    localparam logic signed [SW-1:0] C_BIAS = SW'(BIAS);
    localparam logic signed [SW-1:0] C_MIN  = SW'(-MANTISSABITS);
    localparam logic signed [SW-1:0] C_FIX  = SW'(FIXEDSIZE);

    logic [EXPONENTBITS-1:0] w_exp;
    logic [MANTISSABITS-1:0] w_mant;
    logic                    w_normal;
    logic signed [SW-1:0]    w_eeff;
    logic signed [SW-1:0]    w_shift;
    logic signed [SW-1:0]    w_neg_shift;

    assign w_exp     = i_float[FLOATSIZE-2 -: EXPONENTBITS];
    assign w_mant    = i_float[MANTISSABITS-1:0];
    assign o_sign    = i_float[FLOATSIZE-1];
    assign w_normal  = |w_exp;
    assign o_special = &w_exp;

    // Hidden bit restored for normals; denormals and zero keep a 0 there.
    assign o_sig  = FIXEDSIZE'({w_normal, w_mant});
    // Denormals use the minimum exponent, not zero.
    assign w_eeff = w_normal ? SW'(w_exp) : SW'(1);

    // Signed distance from the significand LSB to the result LSB.
    assign w_shift     = SW'(i_radix) - C_MANT + w_eeff - C_BIAS;
    assign w_neg_shift = -w_shift;

    // Turn the signed distance into a direction and a bounded count.
    always_comb begin
        o_count        = '0;
        o_left         = 1'b0;
        o_pre_overflow = 1'b0;
        if (o_special) begin
            o_pre_overflow = 1'b1;
        end else if (w_shift < C_MIN) begin
            // Shifting out every significand bit is enough to reach zero.
            o_count = CNTW'(MANTISSABITS + 1);
        end else if (w_shift < 0) begin
            o_count = CNTW'(w_neg_shift);
        end else if (w_shift > C_FIX) begin
            o_left         = 1'b1;
            o_count        = CNTW'(FIXEDSIZE);
            o_pre_overflow = 1'b1;
        end else begin
            o_left  = 1'b1;
            o_count = CNTW'(w_shift);
        end
    end

endmodule

// File: rtl/float_to_fixed_seq.sv
// Multi-cycle float-to-fixed converter: plans the shift in one cycle, then
// walks a narrow shifter over the significand SHIFTSTEP bits per cycle and
// returns a saturated two's-complement result over a valid/ready handshake.
module float_to_fixed_seq
    import affhl_pkg::*;
#(
    parameter int FLOATSIZE      = 32,
    parameter int FIXEDSIZE      = 32,
    parameter int RADIXPOINTSIZE = 6,
    parameter int EXPONENTBITS   = 8,
    parameter int MANTISSABITS   = 23,
    parameter int BIAS           = 2 ** (EXPONENTBITS - 1) - 1,
    parameter int SHIFTSTEP      = 4
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic                      InValid,
    output logic                      InReady,
    input  logic [FLOATSIZE-1:0]      InFloat,
    input  logic [RADIXPOINTSIZE-1:0] InRadixPoint,
    output logic                      OutValid,
    input  logic                      OutReady,
    output logic [FIXEDSIZE-1:0]      OutFixed,
    output logic                      OutOverflow
);

    localparam int MAXCNT = (FIXEDSIZE > MANTISSABITS + 1) ? FIXEDSIZE : MANTISSABITS + 1;
    localparam int CNTW   = $clog2(MAXCNT + 1);
    localparam logic [CNTW-1:0]      C_STEP   = CNTW'(SHIFTSTEP);
    localparam logic [FIXEDSIZE-1:0] C_MAXPOS = FIXEDSIZE'(sat_maxpos(FIXEDSIZE));
    localparam logic [FIXEDSIZE-1:0] C_MAXNEG = FIXEDSIZE'(sat_maxneg(FIXEDSIZE));

    state_t                    r_state;
    state_t                    w_next;
    logic [FLOATSIZE-1:0]      r_float;
    logic [RADIXPOINTSIZE-1:0] r_radix;
    logic [FIXEDSIZE-1:0]      r_work;
    logic [CNTW-1:0]           r_cnt;
    logic                      r_left;
    logic                      r_ovf;
    logic                      r_sign;
    logic [FIXEDSIZE-1:0]      r_out_fixed;
    logic                      r_out_ovf;

    logic [FIXEDSIZE-1:0]      w_sig;
    logic                      w_sign;
    logic [CNTW-1:0]           w_count;
    logic                      w_left;
    logic                      w_pre_ovf;
    logic                      w_special;
    logic [CNTW-1:0]           w_k;
    logic [2*FIXEDSIZE-1:0]    w_wide;
    logic                      w_lost;
    logic [FIXEDSIZE-1:0]      w_shifted;
    logic                      w_ovf_final;
    logic [FIXEDSIZE-1:0]      w_result;

    float_shift_plan #(
        .FLOATSIZE      (FLOATSIZE),
        .FIXEDSIZE      (FIXEDSIZE),
        .RADIXPOINTSIZE (RADIXPOINTSIZE),
        .EXPONENTBITS   (EXPONENTBITS),
        .MANTISSABITS   (MANTISSABITS),
        .BIAS           (BIAS),
        .CNTW           (CNTW)
    ) u_plan (
        .i_float        (r_float),
        .i_radix        (r_radix),
        .o_sig          (w_sig),
        .o_sign         (w_sign),
        .o_count        (w_count),
        .o_left         (w_left),
        .o_pre_overflow (w_pre_ovf),
        .o_special      (w_special)
    );

    // One step of the narrow shifter; the upper half of the wide product
    // holds whatever a left shift pushes past the result MSB.
    assign w_k       = (r_cnt < C_STEP) ? r_cnt : C_STEP;
    assign w_wide    = {{FIXEDSIZE{1'b0}}, r_work} << w_k;
    assign w_lost    = |w_wide[2*FIXEDSIZE-1:FIXEDSIZE];
    assign w_shifted = r_left ? w_wide[FIXEDSIZE-1:0] : (r_work >> w_k);

    // A set MSB means the magnitude does not fit the signed result.
    assign w_ovf_final = r_ovf | r_work[FIXEDSIZE-1];
    assign w_result    = w_ovf_final ? (r_sign ? C_MAXNEG : C_MAXPOS)
                                     : (r_sign ? (~r_work + FIXEDSIZE'(1)) : r_work);

    assign InReady     = (r_state == ST_IDLE);
    assign OutValid    = (r_state == ST_DONE);
    assign OutFixed    = r_out_fixed;
    assign OutOverflow = r_out_ovf;

    // Controller state register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state sequencing of one conversion.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (InValid) w_next = ST_CALC;
            ST_CALC:  w_next = (w_special || (w_count == '0)) ? ST_NEG : ST_SHIFT;
            ST_SHIFT: if (r_cnt <= C_STEP) w_next = ST_NEG;
            ST_NEG:   w_next = ST_DONE;
            ST_DONE:  if (OutReady) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Datapath: request capture, shift sequencing and result registration.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_float     <= '0;
            r_radix     <= '0;
            r_work      <= '0;
            r_cnt       <= '0;
            r_left      <= 1'b0;
            r_ovf       <= 1'b0;
            r_sign      <= 1'b0;
            r_out_fixed <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (InValid) begin
                        r_float <= InFloat;
                        r_radix <= InRadixPoint;
                    end
                end
                ST_CALC: begin
                    r_work <= w_sig;
                    r_cnt  <= w_count;
                    r_left <= w_left;
                    r_ovf  <= w_pre_ovf;
                    r_sign <= w_sign;
                end
                ST_SHIFT: begin
                    r_work <= w_shifted;
                    r_cnt  <= r_cnt - w_k;
                    if (r_left && w_lost) r_ovf <= 1'b1;
                end
                ST_NEG: begin
                    r_out_fixed <= w_result;
                    r_out_ovf   <= w_ovf_final;
                end
                default: ;
            endcase
        end
    end

endmodule
